riscv_multicycle_controller: RTL and testbench
==============================================

Name: riscv_multicycle_controller

Overview:
Moore-style FSM controller that sequences a multi-cycle RISC-V datapath. The datapath uses one shared instruction/data memory, one ALU and the IR/oldPC/A/B/ALUOut/Data registers. The block decodes op/func3/func7 and the zero/neg flags into per-state control strobes. A memReady handshake stalls memory states until the memory responds.

Parameters:
STATE_W, 4, width of the state register and of the debug state output.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
op  in  7  IR[6:0]
func3  in  3  IR[14:12]
func7  in  7  IR[31:25]
zero  in  1  ALU result == 0
neg  in  1  ALU result sign bit
memReady  in  1  memory access completes this cycle
PCWrite  out  1  PC load enable
adrSrc  out  1  memory address: 0=PC, 1=ALUOut
memWrite  out  1  memory write strobe
IRWrite  out  1  IR and oldPC load enable
regWrite  out  1  register file write enable
resultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=immExt
ALUSrcA  out  2  00=PC, 01=oldPC, 10=A
ALUSrcB  out  2  00=B, 01=immExt, 10=const 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
instrDone  out  1  one-cycle pulse on the last cycle of each instruction
state  out  STATE_W  current state (debug)

Behaviour:
- Reset:
  - rst=1 asynchronously forces state=FETCH.
  - While rst=1, PCWrite, IRWrite, regWrite, memWrite and instrDone are forced to 0.
  - All other outputs take their FETCH values.
- Default outputs: all enables 0, ALUControl=add, resultSrc=00, ALUSrcA=00, ALUSrcB=00.
- immSrc is decoded combinationally from op in every state:
  - lw, I-ALU, jalr → I
  - sw → S
  - branch → B
  - jal → J
  - lui → U
  - any other op → I
- FETCH:
  - Outputs: adrSrc=0, ALUSrcA=00, ALUSrcB=10, add, resultSrc=10.
  - IRWrite=PCWrite=memReady.
  - Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, add, so ALUOut=oldPC+imm.
  - Next state by op:
    - 0000011 → MEMADR
    - 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - any other op → FETCH with instrDone=1 (treated as a NOP)
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if op=lw, otherwise MEMWRITE.
- MEMREAD: adrSrc=1. Holds until memReady=1, then goes to MEMWB.
- MEMWB: resultSrc=01, regWrite=1, instrDone=1. Goes to FETCH.
- MEMWRITE:
  - adrSrc=1, memWrite=1 held until memReady=1; the write commits on the memReady=1 cycle.
  - On that cycle instrDone=1 and next state is FETCH.
- EXECR:
  - ALUSrcA=10, ALUSrcB=00. Goes to ALUWB.
  - ALUControl by func3:
    - 000 → sub if func7[5]=1, otherwise add
    - 111 → and
    - 110 → or
    - 010 → slt
    - any other func3 → add
- EXECI: ALUSrcA=10, ALUSrcB=01. ALUControl as EXECR except 000 is always add. Goes to ALUWB.
- ALUWB: resultSrc=00, regWrite=1, instrDone=1. Goes to FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, resultSrc=00.
  - PCWrite=taken, where taken is:
    - beq (000): zero
    - bne (001): !zero
    - blt (100): neg
    - bge (101): !neg
    - any other func3: 0
  - instrDone=1. Goes to FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, add, so ALUOut=rs1+imm. Goes to JAL.
- JAL:
  - resultSrc=00, PCWrite=1, so the target is taken from ALUOut.
  - ALUSrcA=01, ALUSrcB=10, add, so ALUOut=oldPC+4.
  - Goes to ALUWB, which writes the link register.
- LUI: resultSrc=11, regWrite=1, instrDone=1. Goes to FETCH.
- Cycle counts with memReady always 1:
  - lw 5
  - sw 4
  - R/I-type 4
  - branch 3
  - jal 4
  - jalr 5
  - lui 3
  - illegal op 2
- Mid-instruction reset abandons the instruction; no strobe fires after rst rises.
- An unreachable state encoding goes to FETCH with default outputs.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants
  - ALUControl, immSrc, resultSrc, ALUSrcA/B codes
  - state enum (FETCH..LUI, 13 states, fits STATE_W=4)
- Sub-module riscv_alu_decoder: combinational; inputs state-class (R/I/other), func3, func7[5]; output ALUControl.

Test Plan:
- Reset with rst pulsed mid-MEMWRITE → state=FETCH immediately; memWrite=0 while rst=1; no further strobes until release.
- lw (op=0000011) with memReady=0 for 2 cycles in FETCH and in MEMREAD → state sequence F,F,F,D,MA,MR,MR,MR,MWB; regWrite only in MWB; instrDone once.
- R-type sub (func3=000, func7=0100000) → ALUControl=001 in EXECR; regWrite=1 in ALUWB; total 4 cycles.
- beq with zero=1 → PCWrite=1 in BRANCH. bne with zero=1 → PCWrite=0. blt with neg=1 → PCWrite=1. bge with neg=1 → PCWrite=0.
- jalr (op=1100111) → states F,D,JALR,JAL,ALUWB. In JAL: PCWrite=1, resultSrc=00, ALUSrcA=01, ALUSrcB=10. regWrite only in ALUWB.
- Illegal op=0000000 → F,D,F; instrDone=1 in D; no PCWrite/regWrite/memWrite asserted in D.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: opcodes, control-field codes,
// FSM state encoding and the immediate-format decode.
package riscv_pkg;

    localparam int unsigned StateW = 4;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmB = 3'b010,
        ImmJ = 3'b011,
        ImmU = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        ResAluOut    = 2'b00,
        ResData      = 2'b01,
        ResAluResult = 2'b10,
        ResImmExt    = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        SrcAPc    = 2'b00,
        SrcAOldPc = 2'b01,
        SrcARegA  = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SrcBRegB = 2'b00,
        SrcBImm  = 2'b01,
        SrcBFour = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        AluClsR,
        AluClsI,
        AluClsOther
    } alu_class_e;

    typedef enum logic [StateW-1:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJalr     = 4'd10,
        StJal      = 4'd11,
        StLui      = 4'd12
    } state_e;

    function automatic imm_src_e imm_src_dec(logic [6:0] op);
        case (op)
            OpLoad, OpItype, OpJalr: return ImmI;
            OpStore:                 return ImmS;
            OpBranch:                return ImmB;
            OpJal:                   return ImmJ;
            OpLui:                   return ImmU;
            default:                 return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/riscv_multicycle_controller_if.sv
// Controller <-> datapath bundle: decoded instruction fields and flags in, control strobes out.
interface riscv_multicycle_controller_if
    import riscv_pkg::*;
#(
    parameter int unsigned STATE_W = StateW
);
    logic [6:0]         op;
    logic [2:0]         func3;
    logic [6:0]         func7;
    logic               zero;
    logic               neg;
    logic               memReady;

    logic               PCWrite;
    logic               adrSrc;
    logic               memWrite;
    logic               IRWrite;
    logic               regWrite;
    logic [1:0]         resultSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [2:0]         ALUControl;
    logic [2:0]         immSrc;
    logic               instrDone;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, func3, func7, zero, neg, memReady,
        output PCWrite, adrSrc, memWrite, IRWrite, regWrite, resultSrc, ALUSrcA, ALUSrcB,
               ALUControl, immSrc, instrDone, state
    );

    modport slave (
        output op, func3, func7, zero, neg, memReady,
        input  PCWrite, adrSrc, memWrite, IRWrite, regWrite, resultSrc, ALUSrcA, ALUSrcB,
               ALUControl, immSrc, instrDone, state
    );
endinterface

// File: rtl/riscv_alu_decoder.sv
// ALU operation select for the execute states; R-type honours func7[5] for sub.
module riscv_alu_decoder
    import riscv_pkg::*;
(
    input  alu_class_e alu_class_i,
    input  logic [2:0] func3_i,
    input  logic       func7_5_i,
    output alu_ctrl_e  alu_ctrl_o
);
    always_comb begin
        alu_ctrl_o = AluAdd;
        if (alu_class_i != AluClsOther) begin
            case (func3_i)
                3'b000:  alu_ctrl_o = (alu_class_i == AluClsR && func7_5_i) ? AluSub : AluAdd;
                3'b111:  alu_ctrl_o = AluAnd;
                3'b110:  alu_ctrl_o = AluOr;
                3'b010:  alu_ctrl_o = AluSlt;
                default: alu_ctrl_o = AluAdd;
            endcase
        end
    end
endmodule

// File: rtl/riscv_multicycle_controller.sv
// Moore FSM sequencing a shared-memory multicycle RISC-V datapath; memory states
// stall on memReady, and reset masks every write strobe.
module riscv_multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned STATE_W = StateW
) (
    input  logic                         clk,
    input  logic                         rst,
    riscv_multicycle_controller_if.master bus
);
    state_e      state_q, state_d;
    logic        pc_write, ir_write, reg_write, mem_write, instr_done, adr_src;
    result_src_e result_src;
    src_a_e      src_a;
    src_b_e      src_b;
    alu_class_e  alu_class;
    alu_ctrl_e   alu_fixed, alu_dec;
    logic        unused_func7;

    assign unused_func7 = ^{bus.func7[6], bus.func7[4:0]};

    riscv_alu_decoder u_alu_decoder (
        .alu_class_i (alu_class),
        .func3_i     (bus.func3),
        .func7_5_i   (bus.func7[5]),
        .alu_ctrl_o  (alu_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = StFetch;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;
        adr_src    = 1'b0;
        result_src = ResAluOut;
        src_a      = SrcAPc;
        src_b      = SrcBRegB;
        alu_class  = AluClsOther;
        alu_fixed  = AluAdd;
        case (state_q)
            StFetch: begin
                src_b      = SrcBFour;
                result_src = ResAluResult;
                ir_write   = bus.memReady;
                pc_write   = bus.memReady;
                state_d    = bus.memReady ? StDecode : StFetch;
            end
            StDecode: begin
                src_a = SrcAOldPc;
                src_b = SrcBImm;
                case (bus.op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpItype:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui:           state_d = StLui;
                    default: begin
                        // Unknown opcodes retire here as a NOP.
                        state_d    = StFetch;
                        instr_done = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                src_a   = SrcARegA;
                src_b   = SrcBImm;
                state_d = (bus.op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                adr_src = 1'b1;
                state_d = bus.memReady ? StMemWb : StMemRead;
            end
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = bus.memReady;
                state_d    = bus.memReady ? StFetch : StMemWrite;
            end
            StExecR: begin
                src_a     = SrcARegA;
                alu_class = AluClsR;
                state_d   = StAluWb;
            end
            StExecI: begin
                src_a     = SrcARegA;
                src_b     = SrcBImm;
                alu_class = AluClsI;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                src_a      = SrcARegA;
                alu_fixed  = AluSub;
                instr_done = 1'b1;
                case (bus.func3)
                    3'b000:  pc_write = bus.zero;
                    3'b001:  pc_write = ~bus.zero;
                    3'b100:  pc_write = bus.neg;
                    3'b101:  pc_write = ~bus.neg;
                    default: pc_write = 1'b0;
                endcase
            end
            StJalr: begin
                src_a   = SrcARegA;
                src_b   = SrcBImm;
                state_d = StJal;
            end
            StJal: begin
                // PC loads the target already in ALUOut while the ALU forms the link value.
                pc_write = 1'b1;
                src_a    = SrcAOldPc;
                src_b    = SrcBFour;
                state_d  = StAluWb;
            end
            StLui: begin
                result_src = ResImmExt;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    assign bus.PCWrite    = pc_write & ~rst;
    assign bus.IRWrite    = ir_write & ~rst;
    assign bus.regWrite   = reg_write & ~rst;
    assign bus.memWrite   = mem_write & ~rst;
    assign bus.instrDone  = instr_done & ~rst;
    assign bus.adrSrc     = adr_src;
    assign bus.resultSrc  = result_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ALUControl = (alu_class == AluClsOther) ? alu_fixed : alu_dec;
    assign bus.immSrc     = imm_src_dec(bus.op);
    assign bus.state      = STATE_W'(state_q);
endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Cycle-by-cycle scoreboard bench: each scenario queues per-cycle stimulus with the
// expected control word, then drains the queue against the controller.
module tb_riscv_multicycle_controller;
    import riscv_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, regw, memw, done, adr;
        logic [1:0] res, a, b;
        logic [2:0] alu, imm;
    } outs_t;

    typedef struct packed {
        logic       r, m;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z, n;
        outs_t      o;
    } row_t;

    localparam logic [2:0] II = 3'b000, IS = 3'b001, IB = 3'b010, IJ = 3'b011, IU = 3'b100;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    row_t sb[$];

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    logic       cur_z, cur_n;

    riscv_multicycle_controller_if #(.STATE_W(4)) bus ();

    riscv_multicycle_controller #(.STATE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t observe();
        outs_t o;
        o.st   = bus.state;
        o.pcw  = bus.PCWrite;
        o.irw  = bus.IRWrite;
        o.regw = bus.regWrite;
        o.memw = bus.memWrite;
        o.done = bus.instrDone;
        o.adr  = bus.adrSrc;
        o.res  = bus.resultSrc;
        o.a    = bus.ALUSrcA;
        o.b    = bus.ALUSrcB;
        o.alu  = bus.ALUControl;
        o.imm  = bus.immSrc;
        return o;
    endfunction

    // str = {PCWrite, IRWrite, regWrite, memWrite, instrDone, adrSrc}
    function automatic row_t row(logic r, logic m, logic [3:0] st, logic [5:0] str,
                                 logic [1:0] res, logic [1:0] a, logic [1:0] b,
                                 logic [2:0] alu, logic [2:0] imm);
        row_t e;
        e.r  = r;      e.m  = m;
        e.op = cur_op; e.f3 = cur_f3; e.f7 = cur_f7; e.z = cur_z; e.n = cur_n;
        e.o  = {st, str, res, a, b, alu, imm};
        return e;
    endfunction

    function automatic row_t fetch(logic m, logic [2:0] imm);
        return row(1'b0, m, StFetch, {m, m, 4'b0000}, 2'b10, 2'b00, 2'b10, 3'b000, imm);
    endfunction

    function automatic row_t decode(logic done, logic [2:0] imm);
        return row(1'b0, 1'b1, StDecode, {4'b0000, done, 1'b0}, 2'b00, 2'b01, 2'b01, 3'b000, imm);
    endfunction

    function automatic row_t aluwb(logic [2:0] imm);
        return row(1'b0, 1'b1, StAluWb, 6'b001010, 2'b00, 2'b00, 2'b00, 3'b000, imm);
    endfunction

    task automatic set_instr(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic z, logic n);
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_n = n;
    endtask

    task automatic test_reset();
        row_t e; outs_t o; int k;
        set_instr(7'b0000000, 3'b000, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(row(1'b1, 1'b1, StFetch, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, II));
        sb.push_back(row(1'b1, 1'b1, StFetch, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, II));
        sb.push_back(fetch(1'b0, II));
        set_instr(OpStore, 3'b010, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, IS));
        sb.push_back(decode(1'b0, IS));
        sb.push_back(row(1'b0, 1'b1, StMemAdr, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, IS));
        sb.push_back(row(1'b0, 1'b0, StMemWrite, 6'b000101, 2'b00, 2'b00, 2'b00, 3'b000, IS));
        // Reset rises between clock edges while the store is still waiting.
        sb.push_back(row(1'b1, 1'b1, StFetch, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, IS));
        sb.push_back(row(1'b1, 1'b1, StFetch, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, IS));
        sb.push_back(fetch(1'b0, IS));
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.r; bus.memReady = e.m; bus.op = e.op; bus.func3 = e.f3;
            bus.func7 = e.f7; bus.zero = e.z; bus.neg = e.n;
            #1;
            o = observe();
            tests++;
            if (o !== e.o) begin
                fails++;
                $display("FAIL reset cycle %0d: got %h want %h", k, o, e.o);
            end
            k++;
        end
    endtask

    task automatic test_lw();
        row_t e; outs_t o; int k;
        set_instr(OpLoad, 3'b010, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b0, II));
        sb.push_back(fetch(1'b0, II));
        sb.push_back(fetch(1'b1, II));
        sb.push_back(decode(1'b0, II));
        sb.push_back(row(1'b0, 1'b1, StMemAdr, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, II));
        sb.push_back(row(1'b0, 1'b0, StMemRead, 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, II));
        sb.push_back(row(1'b0, 1'b0, StMemRead, 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, II));
        sb.push_back(row(1'b0, 1'b1, StMemRead, 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, II));
        sb.push_back(row(1'b0, 1'b1, StMemWb, 6'b001010, 2'b01, 2'b00, 2'b00, 3'b000, II));
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.r; bus.memReady = e.m; bus.op = e.op; bus.func3 = e.f3;
            bus.func7 = e.f7; bus.zero = e.z; bus.neg = e.n;
            #1;
            o = observe();
            tests++;
            if (o !== e.o) begin
                fails++;
                $display("FAIL lw cycle %0d: got %h want %h", k, o, e.o);
            end
            k++;
        end
    endtask

    task automatic test_rtype();
        row_t e; outs_t o; int k;
        set_instr(OpRtype, 3'b000, 7'b0100000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, II));
        sb.push_back(decode(1'b0, II));
        sb.push_back(row(1'b0, 1'b1, StExecR, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, II));
        sb.push_back(aluwb(II));
        set_instr(OpRtype, 3'b111, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, II));
        sb.push_back(decode(1'b0, II));
        sb.push_back(row(1'b0, 1'b1, StExecR, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b010, II));
        sb.push_back(aluwb(II));
        set_instr(OpRtype, 3'b010, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, II));
        sb.push_back(decode(1'b0, II));
        sb.push_back(row(1'b0, 1'b1, StExecR, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b101, II));
        sb.push_back(aluwb(II));
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.r; bus.memReady = e.m; bus.op = e.op; bus.func3 = e.f3;
            bus.func7 = e.f7; bus.zero = e.z; bus.neg = e.n;
            #1;
            o = observe();
            tests++;
            if (o !== e.o) begin
                fails++;
                $display("FAIL rtype cycle %0d: got %h want %h", k, o, e.o);
            end
            k++;
        end
    endtask

    task automatic test_branch();
        row_t e; outs_t o; int k;
        // {func3, zero, neg, taken}
        logic [5:0] cases [6] = '{
            {3'b000, 1'b1, 1'b0, 1'b1}, {3'b001, 1'b1, 1'b0, 1'b0}, {3'b100, 1'b0, 1'b1, 1'b1},
            {3'b101, 1'b0, 1'b1, 1'b0}, {3'b000, 1'b0, 1'b0, 1'b0}, {3'b010, 1'b1, 1'b1, 1'b0}
        };
        foreach (cases[i]) begin
            set_instr(OpBranch, cases[i][5:3], 7'b0000000, cases[i][2], cases[i][1]);
            sb.push_back(fetch(1'b1, IB));
            sb.push_back(decode(1'b0, IB));
            sb.push_back(row(1'b0, 1'b1, StBranch, {cases[i][0], 5'b00010}, 2'b00, 2'b10, 2'b00,
                             3'b001, IB));
        end
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.r; bus.memReady = e.m; bus.op = e.op; bus.func3 = e.f3;
            bus.func7 = e.f7; bus.zero = e.z; bus.neg = e.n;
            #1;
            o = observe();
            tests++;
            if (o !== e.o) begin
                fails++;
                $display("FAIL branch cycle %0d: got %h want %h", k, o, e.o);
            end
            k++;
        end
    endtask

    task automatic test_jalr();
        row_t e; outs_t o; int k;
        set_instr(OpJalr, 3'b000, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, II));
        sb.push_back(decode(1'b0, II));
        sb.push_back(row(1'b0, 1'b1, StJalr, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, II));
        sb.push_back(row(1'b0, 1'b1, StJal, 6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, II));
        sb.push_back(aluwb(II));
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.r; bus.memReady = e.m; bus.op = e.op; bus.func3 = e.f3;
            bus.func7 = e.f7; bus.zero = e.z; bus.neg = e.n;
            #1;
            o = observe();
            tests++;
            if (o !== e.o) begin
                fails++;
                $display("FAIL jalr cycle %0d: got %h want %h", k, o, e.o);
            end
            k++;
        end
    endtask

    task automatic test_illegal();
        row_t e; outs_t o; int k;
        set_instr(7'b0000000, 3'b000, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, II));
        sb.push_back(decode(1'b1, II));
        sb.push_back(fetch(1'b0, II));
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.r; bus.memReady = e.m; bus.op = e.op; bus.func3 = e.f3;
            bus.func7 = e.f7; bus.zero = e.z; bus.neg = e.n;
            #1;
            o = observe();
            tests++;
            if (o !== e.o) begin
                fails++;
                $display("FAIL illegal cycle %0d: got %h want %h", k, o, e.o);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        row_t e; outs_t o; int k;
        set_instr(OpStore, 3'b010, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, IS));
        sb.push_back(decode(1'b0, IS));
        sb.push_back(row(1'b0, 1'b1, StMemAdr, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, IS));
        sb.push_back(row(1'b0, 1'b1, StMemWrite, 6'b000111, 2'b00, 2'b00, 2'b00, 3'b000, IS));
        // I-type ignores func7[5]: addi, never sub.
        set_instr(OpItype, 3'b000, 7'b0100000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, II));
        sb.push_back(decode(1'b0, II));
        sb.push_back(row(1'b0, 1'b1, StExecI, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, II));
        sb.push_back(aluwb(II));
        set_instr(OpItype, 3'b110, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, II));
        sb.push_back(decode(1'b0, II));
        sb.push_back(row(1'b0, 1'b1, StExecI, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b011, II));
        sb.push_back(aluwb(II));
        set_instr(OpLui, 3'b000, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, IU));
        sb.push_back(decode(1'b0, IU));
        sb.push_back(row(1'b0, 1'b1, StLui, 6'b001010, 2'b11, 2'b00, 2'b00, 3'b000, IU));
        set_instr(OpJal, 3'b000, 7'b0000000, 1'b0, 1'b0);
        sb.push_back(fetch(1'b1, IJ));
        sb.push_back(decode(1'b0, IJ));
        sb.push_back(row(1'b0, 1'b1, StJal, 6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, IJ));
        sb.push_back(aluwb(IJ));
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.r; bus.memReady = e.m; bus.op = e.op; bus.func3 = e.f3;
            bus.func7 = e.f7; bus.zero = e.z; bus.neg = e.n;
            #1;
            o = observe();
            tests++;
            if (o !== e.o) begin
                fails++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", k, o, e.o);
            end
            k++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.memReady = 1'b0;
        bus.op       = 7'b0000000;
        bus.func3    = 3'b000;
        bus.func7    = 7'b0000000;
        bus.zero     = 1'b0;
        bus.neg      = 1'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_jalr();
        test_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
